// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Pipeline hazard controller for a simple in-order core. It decides each
//   cycle whether to hold the front end (PC and IF/ID), hold ID/RR, inject a
//   bubble into ID/RR or flush IF/ID. Three situations are handled, in
//   priority order:
//     1. data memory busy        -> freeze the front end and ID/RR
//     2. jump sitting in ID/RR   -> flush IF/ID and bubble ID/RR for 1 cycle
//     3. load-use hazard         -> hold PC/IF/ID and bubble ID/RR for
//                                   LOAD_LAT cycles
//   The control outputs are combinational from the current state and the
//   current inputs. Only the state and the bubble counter are registered.
//
// Parameters:
//   LOAD_LAT      bubble cycles per load-use hazard (1..3)
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   rs, rt        source register fields of the instruction in decode
//   uses_rt       decode instruction actually reads rt
//   rt_id_rr      destination (rt) field of the instruction in ID/RR
//   MemRead_id_rr ID/RR holds a load
//   jump_id_rr    ID/RR holds a jump
//   mem_busy      data memory cannot accept/complete an access this cycle
//   stall_pc      hold the PC
//   stall_if_id   hold the IF/ID register
//   stall         stall input of the ID/RR register
//   bubble_id_rr  force zero control fields into ID/RR
//   flush_if_id   clear IF/ID
//   stall_count   number of cycles with stall_pc=1 (saturating)
//   o_dbg_state   current FSM state (0=RUN, 1=LOAD_WAIT, 2=MEM_WAIT)
//   o_dbg_cnt     current remaining-bubble counter
//
// Optional feature:
//   HAZARD_STATS_EN  when defined, stall_count is a saturating 16-bit
//                    counter of stall_pc cycles. When undefined, no counter
//                    register exists and stall_count is tied to zero.
//
// Handshake note:
//   There is no valid/ready handshake here. mem_busy is a level: while it
//   is high the memory stage is not making progress, and every stage
//   upstream of it must hold its contents.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        uses_rt,
    input  logic [4:0]  rt_id_rr,
    input  logic        MemRead_id_rr,
    input  logic        jump_id_rr,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall,
    output logic        bubble_id_rr,
    output logic        flush_if_id,
    output logic [15:0] stall_count,
    output logic [1:0]  o_dbg_state,
    output logic [1:0]  o_dbg_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    // Counter value loaded on entry to LOAD_WAIT: the first bubble is issued
    // in the RUN cycle that detects the hazard, so LOAD_LAT-1 remain.
    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    state_t     r_state;
    logic [1:0] r_cnt;

    state_t     w_next_state;
    logic [1:0] w_next_cnt;
    logic       w_hazard;
    logic       w_run_rules;
    logic       w_lw_rules;

    logic       w_stall_pc;
    logic       w_stall_if_id;
    logic       w_stall;
    logic       w_bubble;
    logic       w_flush;

    // A load to r0 never creates a dependency, so rt_id_rr==0 is excluded.
    assign w_hazard = MemRead_id_rr && (rt_id_rr != 5'd0) &&
                      ((rt_id_rr == rs) || (uses_rt && (rt_id_rr == rt)));

    // Once memory frees up, MEM_WAIT behaves like whichever state it
    // interrupted: cnt==0 means it came from RUN, otherwise from LOAD_WAIT
    // with bubbles still owed.
    assign w_run_rules = (r_state == RUN) ||
                         ((r_state == MEM_WAIT) && (r_cnt == 2'd0));
    assign w_lw_rules  = (r_state == LOAD_WAIT) ||
                         ((r_state == MEM_WAIT) && (r_cnt != 2'd0));

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_stall_pc    = 1'b0;
        w_stall_if_id = 1'b0;
        w_stall       = 1'b0;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;

        if (mem_busy) begin
            // Memory stall dominates every state; the bubble counter is
            // frozen so the owed bubbles resume afterwards.
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_stall       = 1'b1;
            w_next_state  = MEM_WAIT;
        end else if (w_lw_rules) begin
            w_stall_pc    = 1'b1;
            w_stall_if_id = 1'b1;
            w_bubble      = 1'b1;
            w_next_cnt    = r_cnt - 2'd1;
            w_next_state  = (r_cnt == 2'd1) ? RUN : LOAD_WAIT;
        end else if (w_run_rules) begin
            w_next_state = RUN;
            if (jump_id_rr) begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
            end else if (w_hazard) begin
                w_stall_pc    = 1'b1;
                w_stall_if_id = 1'b1;
                w_bubble      = 1'b1;
                if (LOAD_LAT > 1) begin
                    w_next_state = LOAD_WAIT;
                    w_next_cnt   = LAT_M1;
                end
            end
        end else begin
            // Unreachable encoding: recover to RUN.
            w_next_state = RUN;
            w_next_cnt   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Reset masks all control outputs so no stale stall or bubble leaks out
    // while the FSM is being cleared.
    assign stall_pc     = w_stall_pc    & ~reset;
    assign stall_if_id  = w_stall_if_id & ~reset;
    assign stall        = w_stall       & ~reset;
    assign bubble_id_rr = w_bubble      & ~reset;
    assign flush_if_id  = w_flush       & ~reset;

    assign o_dbg_state  = r_state;
    assign o_dbg_cnt    = r_cnt;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else if (stall_pc && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Two instances (LOAD_LAT=1 and LOAD_LAT=3) share the same inputs. A
// behavioural model tracks "bubbles still owed" per instance and predicts
// the outputs each cycle. Inputs change 1 ns after the rising edge and
// outputs are compared on the falling edge.
// Output vector order: {stall_pc, stall_if_id, stall, bubble_id_rr, flush_if_id}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset         = 1'b1;
    logic [4:0]  rs            = 5'd0;
    logic [4:0]  rt            = 5'd0;
    logic        uses_rt       = 1'b0;
    logic [4:0]  rt_id_rr      = 5'd0;
    logic        MemRead_id_rr = 1'b0;
    logic        jump_id_rr    = 1'b0;
    logic        mem_busy      = 1'b0;

    logic        spc_a, sif_a, stl_a, bub_a, fl_a;
    logic        spc_b, sif_b, stl_b, bub_b, fl_b;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  st_a, st_b, dc_a, dc_b;

    hazard_ctrl #(.LOAD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .uses_rt(uses_rt),
        .rt_id_rr(rt_id_rr), .MemRead_id_rr(MemRead_id_rr),
        .jump_id_rr(jump_id_rr), .mem_busy(mem_busy),
        .stall_pc(spc_a), .stall_if_id(sif_a), .stall(stl_a),
        .bubble_id_rr(bub_a), .flush_if_id(fl_a), .stall_count(cnt_a),
        .o_dbg_state(st_a), .o_dbg_cnt(dc_a)
    );

    hazard_ctrl #(.LOAD_LAT(3)) u_b (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .uses_rt(uses_rt),
        .rt_id_rr(rt_id_rr), .MemRead_id_rr(MemRead_id_rr),
        .jump_id_rr(jump_id_rr), .mem_busy(mem_busy),
        .stall_pc(spc_b), .stall_if_id(sif_b), .stall(stl_b),
        .bubble_id_rr(bub_b), .flush_if_id(fl_b), .stall_count(cnt_b),
        .o_dbg_state(st_b), .o_dbg_cnt(dc_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int owed_a  = 0;   // bubbles still owed by the LOAD_LAT=1 instance
    int owed_b  = 0;   // bubbles still owed by the LOAD_LAT=3 instance
    int stats_a = 0;   // stall_pc cycles seen since reset
    int stats_b = 0;

    function automatic logic hazard_now();
        return MemRead_id_rr && (rt_id_rr != 5'd0) &&
               ((rt_id_rr == rs) || (uses_rt && (rt_id_rr == rt)));
    endfunction

    function automatic logic [4:0] model_out(input int owed);
        if (reset)       return 5'b00000;
        if (mem_busy)    return 5'b11100;
        if (owed > 0)    return 5'b11010;
        if (jump_id_rr)  return 5'b00011;
        if (hazard_now()) return 5'b11010;
        return 5'b00000;
    endfunction

    function automatic int model_next(input int owed, input int lat);
        if (reset)        return 0;
        if (mem_busy)     return owed;
        if (owed > 0)     return owed - 1;
        if (jump_id_rr)   return 0;
        if (hazard_now()) return lat - 1;
        return 0;
    endfunction

    function automatic int stats_next(input int s, input logic [4:0] e);
        if (reset) return 0;
        if (e[4] && s < 65535) return s + 1;
        return s;
    endfunction

    function automatic logic [15:0] stats_exp(input int s);
`ifdef HAZARD_STATS_EN
        return 16'(s);
`else
        return 16'd0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic mb, input logic jp,
                        input logic mr, input logic ut, input logic [4:0] rs_v,
                        input logic [4:0] rt_v, input logic [4:0] rtid_v);
        logic [4:0] ea, eb;
        @(posedge clk);
        #1;
        reset = rst; mem_busy = mb; jump_id_rr = jp; MemRead_id_rr = mr;
        uses_rt = ut; rs = rs_v; rt = rt_v; rt_id_rr = rtid_v;
        @(negedge clk);
        ea = model_out(owed_a);
        eb = model_out(owed_b);
        check("out_a", {27'd0, spc_a, sif_a, stl_a, bub_a, fl_a}, {27'd0, ea});
        check("out_b", {27'd0, spc_b, sif_b, stl_b, bub_b, fl_b}, {27'd0, eb});
        check("excl_a", {31'd0, stl_a & bub_a}, 32'd0);
        check("excl_b", {31'd0, stl_b & bub_b}, 32'd0);
        check("cnt_a", {16'd0, cnt_a}, {16'd0, stats_exp(stats_a)});
        check("cnt_b", {16'd0, cnt_b}, {16'd0, stats_exp(stats_b)});
        owed_a  = model_next(owed_a, 1);
        owed_b  = model_next(owed_b, 3);
        stats_a = stats_next(stats_a, ea);
        stats_b = stats_next(stats_b, eb);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
    endtask

    // ---------------- stimulus ----------------
    int nb_a, nb_b, ns_a, nf_a, ns_b;

    initial begin
        do_reset();
        check("rst_state_a", {30'd0, st_a}, 32'd0);
        check("rst_state_b", {30'd0, st_b}, 32'd0);

        // Single load-use hazard on rs, LOAD_LAT=1 and LOAD_LAT=3.
        nb_a = 0; nb_b = 0;
        step(0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5);
        nb_a += int'(bub_a); nb_b += int'(bub_b);
        for (int i = 0; i < 4; i++) begin
            idle();
            nb_a += int'(bub_a); nb_b += int'(bub_b);
        end
        check("lat1_bubbles", nb_a, 1);
        check("lat3_bubbles", nb_b, 3);
        check("lat3_back_run", {30'd0, st_b}, 32'd0);

        // Load to r0 must never stall.
        nb_a = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
            nb_a += int'(spc_a | sif_a | stl_a | bub_a | fl_a |
                         spc_b | sif_b | stl_b | bub_b | fl_b);
        end
        check("r0_quiet", nb_a, 0);

        // Memory busy with a jump pending: stall wins, flush follows.
        idle();
        ns_a = 0; nf_a = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
            ns_a += int'(stl_a); nf_a += int'(fl_a);
        end
        check("busy_stalls", ns_a, 4);
        check("busy_no_flush", nf_a, 0);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        check("flush_after_busy", {31'd0, fl_a}, 32'd1);
        idle();

        // Memory busy arriving in the second LOAD_WAIT cycle (LOAD_LAT=3).
        nb_b = 0; ns_b = 0;
        step(0, 0, 0, 1, 1, 5'd1, 5'd7, 5'd7);
        nb_b += int'(bub_b);
        idle();
        nb_b += int'(bub_b);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
            nb_b += int'(bub_b); ns_b += int'(stl_b);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            nb_b += int'(bub_b);
        end
        check("resume_bubbles", nb_b, 3);
        check("resume_stalls", ns_b, 2);

        // Reset in the middle of LOAD_WAIT leaves nothing behind.
        step(0, 0, 0, 1, 0, 5'd3, 5'd0, 5'd3);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        check("rst_abandon", {31'd0, bub_b}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
        end

`ifdef HAZARD_STATS_EN
        // Saturation of the stall counter, then clear by reset.
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        end
        check("sat_a", {16'd0, cnt_a}, 32'h0000FFFF);
        check("sat_b", {16'd0, cnt_b}, 32'h0000FFFF);
        do_reset();
        check("sat_clr_a", {16'd0, cnt_a}, 32'd0);
`else
        check("no_stats_a", {16'd0, cnt_a}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
